// File: rtl/fifo_burst_pkg.sv
// Shared definitions for the FIFO burst reader.
// State encoding for the two-state drain FSM and a constant-width helper.
// No logic; imported by fifo_burst_reader.
package fifo_burst_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   // Bits needed to hold values 0..value-1 (at least 1 bit).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/fifo_burst_reader.sv
// Purpose: drains a FWFT FIFO as framed bursts (valid/ready/last); a burst starts only once all its words are buffered.
// Latency: burst starts the cycle after the FIFO count reaches BURST_LEN; data is the FIFO head word with zero latency.
// Backpressure: m_ready low holds m_valid/m_data/m_last and suppresses the pop; stalls may be arbitrarily long.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   fifo_rd_ena       FIFO pop (asserted on each accepted beat)
//   fifo_rd_dat       FIFO head word (first-word-fall-through)
//   fifo_rd_empty     FIFO empty flag
//   fifo_dat_cnt      FIFO occupancy, ADDR_WIDTH+1 bits
//   m_valid/m_data/m_last/m_ready   output stream
//   m_len             length of the current (or most recent) burst
//   busy              high while a burst is in progress
//
// Optional: define FIFO_BURST_TIMEOUT_EN to flush a partial burst after
// TIMEOUT_CYC idle cycles with the FIFO non-empty.
module fifo_burst_reader
   import fifo_burst_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 8,
   parameter int BURST_LEN   = 16,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  fifo_rd_ena,
   input  logic [DATA_WIDTH-1:0] fifo_rd_dat,
   input  logic                  fifo_rd_empty,
   input  logic [ADDR_WIDTH:0]   fifo_dat_cnt,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   input  logic                  m_ready,
   output logic [ADDR_WIDTH:0]   m_len,
   output logic                  busy
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] BURST_LEN_C = CW'(BURST_LEN);

   state_t          state;
   logic [CW-1:0]   beat_cnt;
   logic            burst_rdy;
   logic            tmo_hit;

   // Unsigned compare on the full count width so a completely full FIFO qualifies.
   assign burst_rdy   = (fifo_dat_cnt >= BURST_LEN_C);

   assign busy        = (state == ST_SEND);
   // Empty can never be seen mid-burst (pre-qualified, single reader); gating is defensive.
   assign m_valid     = busy && !fifo_rd_empty;
   assign m_data      = fifo_rd_dat;
   assign m_last      = m_valid && (beat_cnt == (m_len - CW'(1)));
   assign fifo_rd_ena = m_valid && m_ready;

`ifdef FIFO_BURST_TIMEOUT_EN
   localparam int TW = clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] tmo_cnt;

   assign tmo_hit = !fifo_rd_empty && (tmo_cnt == TMO_LAST);

   // Counts idle cycles holding a partial burst; any burst start or an empty FIFO restarts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt <= '0;
      end else if (busy || fifo_rd_empty || burst_rdy || tmo_hit) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + TW'(1);
      end
   end
`else
   // Partial bursts wait in the FIFO until enough words arrive.
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         m_len    <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               // A full burst wins over a timeout flush in the same cycle.
               if (burst_rdy) begin
                  state    <= ST_SEND;
                  m_len    <= BURST_LEN_C;
                  beat_cnt <= '0;
               end else if (tmo_hit) begin
                  state    <= ST_SEND;
                  m_len    <= fifo_dat_cnt;
                  beat_cnt <= '0;
               end
            end
            ST_SEND: begin
               if (fifo_rd_ena) begin
                  if (m_last) begin
                     state    <= ST_IDLE;
                     beat_cnt <= '0;
                  end else begin
                     beat_cnt <= beat_cnt + CW'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifndef SYNTHESIS
   empty_in_send: assert property (@(posedge clk) disable iff (rst) !(busy && fifo_rd_empty));
   param_legal:   assert property (@(posedge clk) disable iff (rst)
                     (TIMEOUT_CYC >= 1) && (BURST_LEN >= 1) && (BURST_LEN <= (1 << ADDR_WIDTH)));
`endif

endmodule
